direction_uart_tx: RTL and testbench

Frame-rate consumer of the camera classifier's `orangeDetected` / `direction` outputs. Samples the classifier result once per frame at the VSYNC rising edge and requires the result to hold for `STABLE_FRAMES` consecutive frames. Each newly stable result is transmitted as one ASCII byte over a UART 8N1 line to the robot controller. It sits between the classifier and the board's UART TX pin.

---
 rtl/direction_uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_direction_uart_tx.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/direction_uart_tx.sv
// Turns the camera classifier's per-frame orange/direction result into one ASCII
// byte on a UART 8N1 line, sent only after the result has held for STABLE_FRAMES frames.
module direction_uart_tx #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int STABLE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       VSYNC,
  input  logic       orangeDetected,
  input  logic [1:0] direction,
  output logic       tx,
  output logic       busy,
  output logic [1:0] stable_direction
);

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      STABLE_N  = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  function automatic logic [7:0] byte_of(input logic [1:0] code);
    case (code)
      2'b01:   byte_of = 8'h52;  // 'R'
      2'b10:   byte_of = 8'h43;  // 'C'
      2'b11:   byte_of = 8'h4C;  // 'L'
      default: byte_of = 8'h4E;  // 'N'
    endcase
  endfunction

  // Frame sampling and stability filter
  logic       vsync_q;
  logic       frame_edge;
  logic [1:0] frame_code;
  logic [1:0] candidate;
  logic [3:0] count;

  assign frame_edge = VSYNC & ~vsync_q;
  assign frame_code = orangeDetected ? direction : 2'b00;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q   <= 1'b0;
      candidate <= 2'b00;
      count     <= 4'd0;
    end else begin
      vsync_q <= VSYNC;
      if (frame_edge) begin
        if (frame_code == candidate) begin
          if (count != STABLE_N) count <= count + 4'd1;
        end else begin
          candidate <= frame_code;
          count     <= 4'd1;
        end
      end
    end
  end

  // Qualification and the depth-1 pending slot
  logic       qualify;
  logic       load;
  logic       pending;
  logic [1:0] pending_code;
  logic [1:0] last_sent;
  logic       sent_any;

  assign qualify = (count == STABLE_N) && (!sent_any || (candidate != last_sent));

  always_ff @(posedge clk) begin
    if (reset) begin
      pending          <= 1'b0;
      pending_code     <= 2'b00;
      last_sent        <= 2'b00;
      sent_any         <= 1'b0;
      stable_direction <= 2'b00;
    end else if (qualify) begin
      // A fresh qualification outranks the FSM consuming the slot this cycle.
      pending          <= 1'b1;
      pending_code     <= candidate;
      stable_direction <= candidate;
      last_sent        <= candidate;
      sent_any         <= 1'b1;
    end else if (load) begin
      pending <= 1'b0;
    end
  end

  // UART transmitter
  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                baud_done;

  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'hFF;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;
    tx      = 1'b1;
    busy    = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (pending) begin
          load    = 1'b1;
          shift_d = byte_of(pending_code);
          baud_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        tx = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        tx = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit so back-to-back bytes leave no idle gap.
          if (pending) begin
            load    = 1'b1;
            shift_d = byte_of(pending_code);
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_direction_uart_tx.sv
// Bench for direction_uart_tx: directed scenarios plus a randomized frame stream
// compared against a frame-history model, with UART monitors decoding the tx lines.
`timescale 1ns/1ps
module tb_direction_uart_tx;

  localparam int CPB        = 4;
  localparam int STABLE     = 3;
  localparam int CLK_PERIOD = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       VSYNC;
  logic       orangeDetected;
  logic [1:0] direction;
  logic       tx, busy;
  logic [1:0] stable_direction;
  logic       tx1, busy1;
  logic [1:0] stable_direction1;
  logic [1:0] txv;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         stop_err = 0;
  logic       mon_en   = 1'b1;
  logic [7:0] rx0[$];
  logic [7:0] rx1[$];
  time        t1_q[$];
  logic [7:0] ascii [4] = '{8'h4E, 8'h52, 8'h43, 8'h4C};

  always #(CLK_PERIOD / 2) clk = ~clk;

  direction_uart_tx #(.CLKS_PER_BIT(CPB), .STABLE_FRAMES(STABLE)) dut (
    .clk              (clk),
    .reset            (reset),
    .VSYNC            (VSYNC),
    .orangeDetected   (orangeDetected),
    .direction        (direction),
    .tx               (tx),
    .busy             (busy),
    .stable_direction (stable_direction)
  );

  // Second instance exercises the single-frame filter and the overwrite path.
  direction_uart_tx #(.CLKS_PER_BIT(CPB), .STABLE_FRAMES(1)) dut1 (
    .clk              (clk),
    .reset            (reset),
    .VSYNC            (VSYNC),
    .orangeDetected   (orangeDetected),
    .direction        (direction),
    .tx               (tx1),
    .busy             (busy1),
    .stable_direction (stable_direction1)
  );

  assign txv = {tx1, tx};

  // UART receiver: samples each bit near its middle on the falling clock edge.
  task automatic uart_mon(input int id);
    logic [7:0] b;
    logic       start_bit, stop_bit;
    time        t0;
    forever begin
      wait (txv[id] === 1'b1);
      wait (txv[id] === 1'b0);
      t0 = $time;
      repeat (CPB / 2) @(negedge clk);
      start_bit = txv[id];
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = txv[id];
      end
      repeat (CPB) @(negedge clk);
      stop_bit = txv[id];
      if (mon_en && start_bit === 1'b0) begin
        if (stop_bit !== 1'b1) stop_err++;
        if (id == 0) begin
          rx0.push_back(b);
        end else begin
          rx1.push_back(b);
          t1_q.push_back(t0);
        end
      end
    end
  endtask

  initial uart_mon(0);
  initial uart_mon(1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse(input logic od, input logic [1:0] dir);
    @(posedge clk); #1;
    orangeDetected = od;
    direction      = dir;
    VSYNC          = 1'b1;
    @(posedge clk); #1;
    VSYNC = 1'b0;
  endtask

  task automatic do_reset();
    idle(100);
    @(posedge clk); #1;
    reset = 1'b1;
    VSYNC = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rx0.delete();
    rx1.delete();
    t1_q.delete();
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    VSYNC          = 1'b0;
    orangeDetected = 1'b0;
    direction      = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (stable_direction !== 2'b00) begin
      n_fail++; $display("FAIL reset_stable_dir: got %b expected 00", stable_direction);
    end
    n_checks++;
    if ({tx1, busy1, stable_direction1} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_dut1: got %b expected 1000", {tx1, busy1, stable_direction1});
    end
    reset = 1'b0;
    idle(20);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic_send();
    logic [7:0] exp_byte;
    logic       exp_bit;
    do_reset();
    pulse(1'b1, 2'b10); idle(4);
    pulse(1'b1, 2'b10); idle(4);
    pulse(1'b1, 2'b10);
    @(posedge clk); #1;
    n_checks++;
    if ({tx, busy} !== 2'b10) begin
      n_fail++; $display("FAIL basic_latency_early: got tx/busy %b expected 10", {tx, busy});
    end
    @(posedge clk); #1;
    n_checks++;
    if (stable_direction !== 2'b10) begin
      n_fail++; $display("FAIL basic_stable_dir: got %b expected 10", stable_direction);
    end
    exp_byte = 8'h43;
    for (int k = 0; k < 10; k++) begin
      exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp_byte[k-1];
      n_checks++;
      if (tx !== exp_bit) begin
        n_fail++; $display("FAIL basic_bit%0d: got %b expected %b", k, tx, exp_bit);
      end
      if (k < 9) begin
        repeat (CPB) @(posedge clk);
        #1;
      end
    end
    repeat (CPB - 1) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_last_stop: got %b expected 1", busy); end
    @(posedge clk); #1;
    n_checks++;
    if ({tx, busy} !== 2'b10) begin
      n_fail++; $display("FAIL basic_end_of_frame: got tx/busy %b expected 10", {tx, busy});
    end
    idle(10);
    n_checks++;
    if (rx0.size() != 1 || rx0[0] !== 8'h43) begin
      n_fail++; $display("FAIL basic_rx: got %0d bytes first %h expected 1 byte 43", rx0.size(),
                         (rx0.size() > 0) ? rx0[0] : 8'h00);
    end
    rx0.delete();
  endtask

  task automatic test_filter_reset();
    logic [1:0] seq [5] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    foreach (seq[i]) begin
      pulse(1'b1, seq[i]);
      idle(4);
    end
    idle(60);
    n_checks++;
    if (rx0.size() != 0) begin
      n_fail++; $display("FAIL filter_no_send: got %0d bytes expected 0", rx0.size());
    end
    n_checks++;
    if (stable_direction !== 2'b10) begin
      n_fail++; $display("FAIL filter_stable_dir: got %b expected 10", stable_direction);
    end
    pulse(1'b1, 2'b11);
    idle(60);
    n_checks++;
    if (rx0.size() != 1 || rx0[0] !== 8'h4C) begin
      n_fail++; $display("FAIL filter_third_l: got %0d bytes first %h expected 1 byte 4c", rx0.size(),
                         (rx0.size() > 0) ? rx0[0] : 8'h00);
    end
    rx0.delete();
  endtask

  task automatic test_no_resend();
    repeat (6) begin
      pulse(1'b1, 2'b01);
      idle(4);
    end
    idle(60);
    n_checks++;
    if (rx0.size() != 1 || rx0[0] !== 8'h52) begin
      n_fail++; $display("FAIL noresend_r: got %0d bytes first %h expected 1 byte 52", rx0.size(),
                         (rx0.size() > 0) ? rx0[0] : 8'h00);
    end
    repeat (3) begin
      pulse(1'b0, 2'($urandom_range(1, 3)));
      idle(4);
    end
    idle(60);
    n_checks++;
    if (rx0.size() != 2 || rx0[1] !== 8'h4E) begin
      n_fail++; $display("FAIL noresend_n: got %0d bytes last %h expected 2 bytes last 4e", rx0.size(),
                         (rx0.size() > 0) ? rx0[rx0.size()-1] : 8'h00);
    end
    n_checks++;
    if (stable_direction !== 2'b00) begin
      n_fail++; $display("FAIL noresend_stable_dir: got %b expected 00", stable_direction);
    end
  endtask

  task automatic test_overwrite_busy();
    do_reset();
    pulse(1'b1, 2'b01); idle(3);
    pulse(1'b1, 2'b10); idle(3);
    pulse(1'b1, 2'b11);
    idle(100);
    n_checks++;
    if (rx1.size() != 2) begin
      n_fail++; $display("FAIL overwrite_count: got %0d bytes expected 2", rx1.size());
    end else begin
      n_checks++;
      if (rx1[0] !== 8'h52 || rx1[1] !== 8'h4C) begin
        n_fail++; $display("FAIL overwrite_bytes: got %h %h expected 52 4c", rx1[0], rx1[1]);
      end
      n_checks++;
      if (t1_q[1] - t1_q[0] !== time'(10 * CPB * CLK_PERIOD)) begin
        n_fail++; $display("FAIL overwrite_gap: got %0t expected %0d", t1_q[1] - t1_q[0],
                           10 * CPB * CLK_PERIOD);
      end
    end
    n_checks++;
    if (stable_direction1 !== 2'b11) begin
      n_fail++; $display("FAIL overwrite_stable_dir: got %b expected 11", stable_direction1);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic saw_busy;
    do_reset();
    mon_en = 1'b0;
    pulse(1'b1, 2'b10); idle(4);
    pulse(1'b1, 2'b10); idle(4);
    pulse(1'b1, 2'b10);
    repeat (19) @(posedge clk);
    #1;
    n_checks++;
    if ({tx, busy} !== 2'b01) begin
      n_fail++; $display("FAIL midbyte_bit3: got tx/busy %b expected 01", {tx, busy});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({tx, busy} !== 2'b10) begin
      n_fail++; $display("FAIL midbyte_reset: got tx/busy %b expected 10", {tx, busy});
    end
    reset    = 1'b0;
    saw_busy = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (busy) saw_busy = 1'b1;
    end
    n_checks++;
    if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL midbyte_resumed: got busy 1 expected 0"); end
    rx0.delete();
    mon_en = 1'b1;
    pulse(1'b1, 2'b10); idle(4);
    pulse(1'b1, 2'b10);
    idle(60);
    n_checks++;
    if (rx0.size() != 0) begin
      n_fail++; $display("FAIL midbyte_two_frames: got %0d bytes expected 0", rx0.size());
    end
    pulse(1'b1, 2'b10);
    idle(60);
    n_checks++;
    if (rx0.size() != 1 || rx0[0] !== 8'h43) begin
      n_fail++; $display("FAIL midbyte_three_frames: got %0d bytes first %h expected 1 byte 43",
                         rx0.size(), (rx0.size() > 0) ? rx0[0] : 8'h00);
    end
  endtask

  task automatic test_vsync_held();
    logic saw_busy;
    do_reset();
    @(posedge clk); #1;
    orangeDetected = 1'b1;
    direction      = 2'b11;
    VSYNC          = 1'b1;
    saw_busy       = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (busy) saw_busy = 1'b1;
    end
    VSYNC = 1'b0;
    n_checks++;
    if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL vsync_held_extra_edges: got busy 1 expected 0"); end
    idle(4);
    pulse(1'b1, 2'b11);
    idle(60);
    n_checks++;
    if (rx0.size() != 0) begin
      n_fail++; $display("FAIL vsync_held_second: got %0d bytes expected 0", rx0.size());
    end
    pulse(1'b1, 2'b11);
    idle(60);
    n_checks++;
    if (rx0.size() != 1 || rx0[0] !== 8'h4C) begin
      n_fail++; $display("FAIL vsync_held_third: got %0d bytes first %h expected 1 byte 4c", rx0.size(),
                         (rx0.size() > 0) ? rx0[0] : 8'h00);
    end
  endtask

  // Model: a value is sent when its trailing run of identical frame codes reaches
  // STABLE and it differs from the last value sent (or nothing was sent yet).
  task automatic test_random();
    logic [1:0] hist[$];
    logic [7:0] exp_q[$];
    logic       sent;
    logic [1:0] last;
    logic       od;
    logic [1:0] dir, code;
    int         run;
    do_reset();
    sent = 1'b0;
    last = 2'b00;
    od   = 1'b0;
    dir  = 2'b00;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 9) >= 7) begin
        od  = 1'($urandom_range(0, 1));
        dir = 2'($urandom_range(0, 3));
      end
      pulse(od, dir);
      code = od ? dir : 2'b00;
      hist.push_back(code);
      run = 0;
      for (int j = hist.size() - 1; j >= 0 && hist[j] == code; j--) run++;
      if (run == STABLE && (!sent || code != last)) begin
        exp_q.push_back(ascii[code]);
        sent = 1'b1;
        last = code;
      end
      idle($urandom_range(48, 60));
    end
    idle(60);
    n_checks++;
    if (rx0.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_count: got %0d bytes expected %0d", rx0.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_checks++;
        if (rx0[k] !== exp_q[k]) begin
          n_fail++; $display("FAIL random_byte%0d: got %h expected %h", k, rx0[k], exp_q[k]);
        end
      end
    end
    n_checks++;
    if (stable_direction !== last) begin
      n_fail++; $display("FAIL random_stable_dir: got %b expected %b", stable_direction, last);
    end
    n_checks++;
    if (stop_err != 0) begin
      n_fail++; $display("FAIL stop_bits: got %0d bad stop bits expected 0", stop_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_send();
    test_filter_reset();
    test_no_resend();
    test_overwrite_busy();
    test_reset_mid_byte();
    test_vsync_held();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
